// File: rtl/multicycle_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : multicycle_datapath
// Purpose : FSM-sequenced CPU datapath. It holds the register file, ALU,
//           shifter, flag register and program counter. It accepts one decoded
//           instruction per valid/ready handshake and runs it through execute,
//           an optional memory access (req/ack) and writeback.
// Option  : define MULTICYCLE_DATAPATH_MUL_EN to add an iterative shift-add
//           multiplier for alu_op 7 (WIDTH cycles in state MUL).
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_datapath #(
  parameter int               WIDTH    = 16,
  parameter int               REGBITS  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_valid,
  output logic               inst_ready,
  input  logic [2:0]         op,
  input  logic [2:0]         alu_op,
  input  logic [REGBITS-1:0] rdest,
  input  logic [REGBITS-1:0] rsrc,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  input  logic [3:0]         cond,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack,
  output logic [WIDTH-1:0]   pc,
  output logic [4:0]         flags,
  output logic               retire
);

  localparam int NREGS = 2**REGBITS;
  localparam int MSB   = WIDTH - 1;

  // Flag bit positions inside {N,Z,F,L,C}
  localparam int FN = 4;
  localparam int FZ = 3;
  localparam int FF = 2;
  localparam int FL = 1;
  localparam int FC = 0;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

  localparam logic [2:0] OP_ALU   = 3'd0;
  localparam logic [2:0] OP_SHIFT = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STOR  = 3'd3;
  localparam logic [2:0] OP_LUI   = 3'd4;
  localparam logic [2:0] OP_BCOND = 3'd5;
  localparam logic [2:0] OP_JCOND = 3'd6;
  localparam logic [2:0] OP_JAL   = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_CMP = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_MOV = 3'd6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
`ifdef MULTICYCLE_DATAPATH_MUL_EN
  localparam logic [1:0] S_MUL   = 2'd3;
  localparam logic [2:0] ALU_MUL = 3'd7;
  localparam int         CNTW    = $clog2(WIDTH);
`endif

  logic [1:0]         state, state_nxt;
  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   pc_r;
  logic [4:0]         flags_r;
  logic               retire_r;

  // Instruction fields and operands frozen at accept time
  logic [2:0]         op_q, alu_op_q;
  logic [REGBITS-1:0] rdest_q;
  logic [3:0]         cond_q;
  logic [WIDTH-1:0]   imm_q, a_q, b_q, src_q;

  logic               is_mem, is_mul, taken;
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [WIDTH-1:0]   shamt, shift_res;
  logic               ex_wr;
  logic [WIDTH-1:0]   ex_res, ex_pc;
  logic [4:0]         ex_flags;

  assign is_mem = (op_q == OP_LOAD) || (op_q == OP_STOR);

`ifdef MULTICYCLE_DATAPATH_MUL_EN
  logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, mul_sum;
  logic [CNTW-1:0]  mul_cnt;
  logic             mul_last;
  assign is_mul   = (op_q == OP_ALU) && (alu_op_q == ALU_MUL);
  assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last = (mul_cnt == CNTW'(WIDTH - 1));
`else
  assign is_mul = 1'b0;
`endif

  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ext = {1'b0, a_q} - {1'b0, b_q};

  // Signed shift amount: positive shifts left, negative shifts right
  assign shamt     = b_q[MSB] ? (~b_q + ONE) : b_q;
  assign shift_res = (shamt >= WVAL) ? '0 :
                     (b_q[MSB] ? (a_q >> shamt) : (a_q << shamt));

  assign mem_addr  = src_q;
  assign mem_wdata = a_q;
  assign pc        = pc_r;
  assign flags     = flags_r;
  assign retire    = retire_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (inst_valid) state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_mem) state_nxt = S_MEM;
`ifdef MULTICYCLE_DATAPATH_MUL_EN
        else if (is_mul) state_nxt = S_MUL;
`endif
        else state_nxt = S_IDLE;
      end
      S_MEM:  if (mem_ack) state_nxt = S_IDLE;
`ifdef MULTICYCLE_DATAPATH_MUL_EN
      S_MUL:  if (mul_last) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; mem_req follows state so reset drops it at once
  always_comb begin
    inst_ready = (state == S_IDLE);
    mem_req    = (state == S_MEM);
    mem_we     = (state == S_MEM) && (op_q == OP_STOR);
  end

  // Branch/jump condition evaluated against the current flags
  always_comb begin
    case (cond_q)
      4'd0:    taken =  flags_r[FZ];
      4'd1:    taken = ~flags_r[FZ];
      4'd2:    taken =  flags_r[FC];
      4'd3:    taken = ~flags_r[FC];
      4'd4:    taken =  flags_r[FL];
      4'd5:    taken = ~flags_r[FL];
      4'd6:    taken =  flags_r[FN];
      4'd7:    taken = ~flags_r[FN];
      4'd8:    taken =  flags_r[FF];
      4'd9:    taken = ~flags_r[FF];
      4'd14:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Single-cycle execute result, flag and PC update
  always_comb begin
    ex_wr    = 1'b0;
    ex_res   = b_q;
    ex_flags = flags_r;
    ex_pc    = pc_r + ONE;
    case (op_q)
      OP_ALU: begin
        case (alu_op_q)
          ALU_ADD: begin
            ex_wr        = 1'b1;
            ex_res       = sum_ext[MSB:0];
            ex_flags[FC] = sum_ext[WIDTH];
            ex_flags[FF] = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
          end
          ALU_SUB: begin
            ex_wr        = 1'b1;
            ex_res       = diff_ext[MSB:0];
            ex_flags[FC] = diff_ext[WIDTH];
            ex_flags[FF] = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
          end
          ALU_CMP: begin
            ex_flags[FZ] = (a_q == b_q);
            ex_flags[FL] = (a_q < b_q);
            ex_flags[FN] = ($signed(a_q) < $signed(b_q));
          end
          ALU_AND: begin ex_wr = 1'b1; ex_res = a_q & b_q; end
          ALU_OR:  begin ex_wr = 1'b1; ex_res = a_q | b_q; end
          ALU_XOR: begin ex_wr = 1'b1; ex_res = a_q ^ b_q; end
          ALU_MOV: begin ex_wr = 1'b1; ex_res = b_q; end
          default: ;
        endcase
      end
      OP_SHIFT: begin ex_wr = 1'b1; ex_res = shift_res; end
      OP_LUI:   begin ex_wr = 1'b1; ex_res = {imm_q[7:0], {(WIDTH-8){1'b0}}}; end
      OP_BCOND: if (taken) ex_pc = pc_r + imm_q;
      OP_JCOND: if (taken) ex_pc = src_q;
      OP_JAL: begin
        ex_wr  = 1'b1;
        ex_res = pc_r + ONE;
        ex_pc  = src_q;
      end
      default: ;
    endcase
  end

  // Datapath registers: capture, writeback, flags, PC and retire pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pc_r     <= RESET_PC;
      flags_r  <= '0;
      retire_r <= 1'b0;
      op_q     <= '0;
      alu_op_q <= '0;
      rdest_q  <= '0;
      cond_q   <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      src_q    <= '0;
    end else begin
      retire_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_valid) begin
            op_q     <= op;
            alu_op_q <= alu_op;
            rdest_q  <= rdest;
            cond_q   <= cond;
            imm_q    <= imm;
            a_q      <= regs[rdest];
            b_q      <= use_imm ? imm : regs[rsrc];
            src_q    <= regs[rsrc];
          end
        end
        S_EXEC: begin
          if (!is_mem && !is_mul) begin
            if (ex_wr) regs[rdest_q] <= ex_res;
            flags_r  <= ex_flags;
            pc_r     <= ex_pc;
            retire_r <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op_q == OP_LOAD) regs[rdest_q] <= mem_rdata;
            pc_r     <= pc_r + ONE;
            retire_r <= 1'b1;
          end
        end
`ifdef MULTICYCLE_DATAPATH_MUL_EN
        S_MUL: begin
          if (mul_last) begin
            regs[rdest_q] <= mul_sum;
            pc_r          <= pc_r + ONE;
            retire_r      <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_DATAPATH_MUL_EN
  // Shift-add multiplier: one multiplier bit consumed per MUL cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (state == S_EXEC) begin
      mul_acc    <= '0;
      mul_mcand  <= a_q;
      mul_mplier <= b_q;
      mul_cnt    <= '0;
    end else if (state == S_MUL) begin
      mul_acc    <= mul_sum;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + CNTW'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_multicycle_datapath
// Purpose : Scoreboard bench for multicycle_datapath. An integer-arithmetic
//           reference model predicts pc/flags/latency per instruction and the
//           memory transactions; monitors compare when the DUT retires or
//           completes a memory access.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;

  typedef struct { logic [15:0] pc; logic [4:0] fl; int lat; } exp_t;
  typedef struct { bit we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rdata; int dly; } mem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [2:0]  op = '0, alu_op = '0;
  logic [3:0]  rdest = '0, rsrc = '0, cond = '0;
  logic [15:0] imm = '0;
  logic        use_imm = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [15:0] pc;
  logic [4:0]  flags;
  logic        retire;

  multicycle_datapath #(.WIDTH(16), .REGBITS(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .op(op), .alu_op(alu_op), .rdest(rdest), .rsrc(rsrc), .imm(imm),
    .use_imm(use_imm), .cond(cond), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc(pc), .flags(flags), .retire(retire)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, accept_cyc = 0, last_lat = 0, retire_cnt = 0;
  int req_cycles = 0, last_req_cycles = 0;
  bit in_txn = 0;
  logic [15:0] t_addr, t_wdata, last_wdata = '0;
  exp_t exp_q[$];
  mem_t mem_q[$];
  exp_t e_mon;

  // Reference model state
  logic [15:0] mreg [16];
  logic [15:0] mpc;
  logic [4:0]  mflags;   // {N,Z,F,L,C}

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    case (c)
      0: return f[3];   1: return !f[3];
      2: return f[0];   3: return !f[0];
      4: return f[1];   5: return !f[1];
      6: return f[4];   7: return !f[4];
      8: return f[2];   9: return !f[2];
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sgn(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    mpc = '0;
    mflags = '0;
  endtask

  // One instruction through the model: returns expected scoreboard entry
  task automatic model_step(input logic [2:0] o, input logic [2:0] ao, input logic [3:0] rd,
                            input logic [3:0] rs, input logic [15:0] im, input logic ui,
                            input logic [3:0] cd, input logic [15:0] rdat, input int dly,
                            output exp_t e, output bit is_mem, output mem_t m);
    int a, b, sa, sb, r, s, npc, tgt;
    longint p;
    a = int'(mreg[rd]);
    b = ui ? int'(im) : int'(mreg[rs]);
    sa = sgn(a);
    sb = sgn(b);
    npc = (int'(mpc) + 1) % 65536;
    e.lat = 2;
    is_mem = 0;
    m = '{we: 1'b0, addr: mreg[rs], wdata: mreg[rd], rdata: rdat, dly: dly};
    case (o)
      3'd0: case (ao)
        3'd0: begin r = a + b; s = sa + sb; mflags[0] = (r > 65535);
                    mflags[2] = (s > 32767) || (s < -32768); mreg[rd] = 16'(r); end
        3'd1: begin r = a - b; s = sa - sb; mflags[0] = (a < b);
                    mflags[2] = (s > 32767) || (s < -32768); mreg[rd] = 16'(r); end
        3'd2: begin mflags[3] = (a == b); mflags[1] = (a < b); mflags[4] = (sa < sb); end
        3'd3: mreg[rd] = 16'(a & b);
        3'd4: mreg[rd] = 16'(a | b);
        3'd5: mreg[rd] = 16'(a ^ b);
        3'd6: mreg[rd] = 16'(b);
        default: begin
`ifdef MULTICYCLE_DATAPATH_MUL_EN
          p = longint'(a) * longint'(b);
          mreg[rd] = 16'(p);
          e.lat = 18;
`else
          p = 0;
`endif
        end
      endcase
      3'd1: begin
        if (sb >= 0) r = (sb >= 16) ? 0 : (a << sb);
        else         r = (-sb >= 16) ? 0 : (a >> (-sb));
        mreg[rd] = 16'(r);
      end
      3'd2: begin is_mem = 1; e.lat = 0; mreg[rd] = rdat; end
      3'd3: begin is_mem = 1; e.lat = 0; m.we = 1'b1; end
      3'd4: mreg[rd] = 16'((int'(im) % 256) * 256);
      3'd5: if (cond_ok(cd, mflags)) npc = (int'(mpc) + sgn(int'(im)) + 65536) % 65536;
      3'd6: if (cond_ok(cd, mflags)) npc = int'(mreg[rs]);
      default: begin tgt = int'(mreg[rs]); mreg[rd] = 16'(npc); npc = tgt; end
    endcase
    mpc = 16'(npc);
    e.pc = mpc;
    e.fl = mflags;
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] ao, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [15:0] im, input logic ui,
                       input logic [3:0] cd, input int dly, input logic [15:0] rdat,
                       input bit wait_done);
    exp_t e; mem_t m; bit is_mem; int k;
    k = 0;
    while (!inst_ready && k < 100) begin @(negedge clk); #1; k++; end
    if (!inst_ready) bound_expired("inst_ready_wait");
    model_step(o, ao, rd, rs, im, ui, cd, rdat, dly, e, is_mem, m);
    exp_q.push_back(e);
    if (is_mem) mem_q.push_back(m);
    op = o; alu_op = ao; rdest = rd; rsrc = rs; imm = im; use_imm = ui; cond = cd;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    inst_valid = 1'b0;
    if (wait_done) begin
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin @(negedge clk); #1; k++; end
      if (exp_q.size() != 0) begin
        bound_expired("retire_wait");
        exp_q.delete();
        mem_q.delete();
      end
    end
  endtask

  task automatic alu(input logic [2:0] ao, input logic [3:0] rd, input logic [15:0] im);
    issue(3'd0, ao, rd, 4'd0, im, 1'b1, 4'd0, 0, 16'h0, 1'b1);
  endtask

  // Read a register out through a store and compare the write data
  task automatic store_read(input string name, input logic [3:0] r, input logic [15:0] v);
    issue(3'd3, 3'd0, r, 4'd0, 16'h0, 1'b0, 4'd0, $urandom_range(0, 2), 16'h0, 1'b1);
    check(name, last_wdata, v);
  endtask

  // Retire monitor: pops one expectation per retire pulse
  always @(negedge clk) begin
    if (retire) begin
      retire_cnt++;
      if (exp_q.size() == 0) bound_expired("retire_unexpected");
      else begin
        e_mon = exp_q.pop_front();
        check("pc", pc, e_mon.pc);
        check("flags", flags, e_mon.fl);
        last_lat = cyc - accept_cyc + 1;
        if (e_mon.lat > 0) check("latency", last_lat, e_mon.lat);
      end
    end
  end

  // Memory responder and checker; also drives stray acks outside requests
  always @(negedge clk) begin
    if (mem_req) begin
      if (mem_q.size() == 0) begin
        bound_expired("mem_unexpected");
        mem_ack = 1'b1;
      end else begin
        if (!in_txn) begin
          in_txn = 1; req_cycles = 0; t_addr = mem_addr; t_wdata = mem_wdata;
        end else begin
          check("mem_addr_stable", mem_addr, t_addr);
          check("mem_wdata_stable", mem_wdata, t_wdata);
        end
        req_cycles++;
        if (req_cycles == mem_q[0].dly + 1) begin
          check("mem_we", mem_we, mem_q[0].we);
          check("mem_addr", mem_addr, mem_q[0].addr);
          if (mem_q[0].we) check("mem_wdata", mem_wdata, mem_q[0].wdata);
          last_req_cycles = req_cycles;
          last_wdata = mem_wdata;
          mem_rdata = mem_q[0].rdata;
          mem_ack = 1'b1;
          in_txn = 0;
          void'(mem_q.pop_front());
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end
    end else begin
      if (in_txn) begin bound_expired("mem_req_dropped"); in_txn = 0; end
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, k;
    logic [2:0] o;
    logic [15:0] im;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 16'h0000);
    check("rst_flags", flags, 5'h00);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_retire", retire, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_ready", inst_ready, 1'b1);
    for (int r = 0; r < 16; r++) store_read("rst_reg", 4'(r), 16'h0000);

    // Overflow on ADD, then signed compare
    alu(3'd6, 4'd1, 16'h7FFF);
    alu(3'd0, 4'd1, 16'h0001);
    check("add_F", flags[2], 1'b1);
    check("add_C", flags[0], 1'b0);
    store_read("add_res", 4'd1, 16'h8000);
    alu(3'd2, 4'd1, 16'h0001);
    check("cmp_N", flags[4], 1'b1);
    check("cmp_L", flags[1], 1'b0);
    check("cmp_Z", flags[3], 1'b0);

    // Slow store: ack after three wait cycles
    rc = retire_cnt;
    issue(3'd3, 3'd0, 4'd1, 4'd0, 16'h0, 1'b0, 4'd0, 3, 16'h0, 1'b1);
    check("stor_req_cycles", last_req_cycles, 4);
    check("stor_wdata", last_wdata, 16'h8000);
    check("stor_retires", retire_cnt - rc, 1);
    issue(3'd2, 3'd0, 4'd7, 4'd0, 16'h0, 1'b0, 4'd0, 1, 16'hBEEF, 1'b1);
    store_read("load_res", 4'd7, 16'hBEEF);

    // Branches and jumps
    alu(3'd2, 4'd0, 16'h0000);
    alu(3'd6, 4'd2, 16'h0010);
    issue(3'd6, 3'd0, 4'd0, 4'd2, 16'h0, 1'b0, 4'd14, 0, 16'h0, 1'b1);
    check("jcond_pc", pc, 16'h0010);
    issue(3'd5, 3'd0, 4'd0, 4'd0, 16'hFFFC, 1'b1, 4'd0, 0, 16'h0, 1'b1);
    check("beq_pc", pc, 16'h000C);
    issue(3'd6, 3'd0, 4'd0, 4'd2, 16'h0, 1'b0, 4'd14, 0, 16'h0, 1'b1);
    issue(3'd5, 3'd0, 4'd0, 4'd0, 16'hFFFC, 1'b1, 4'd15, 0, 16'h0, 1'b1);
    check("bnever_pc", pc, 16'h0011);
    alu(3'd6, 4'd2, 16'h0100);
    issue(3'd7, 3'd0, 4'd5, 4'd2, 16'h0, 1'b0, 4'd0, 0, 16'h0, 1'b1);
    check("jal_pc", pc, 16'h0100);
    store_read("jal_link", 4'd5, 16'h0013);
    alu(3'd6, 4'd3, 16'hFFFF);
    issue(3'd6, 3'd0, 4'd0, 4'd3, 16'h0, 1'b0, 4'd14, 0, 16'h0, 1'b1);
    alu(3'd6, 4'd4, 16'h0000);
    check("pc_wrap", pc, 16'h0000);

    // Shifts
    alu(3'd6, 4'd3, 16'h8001);
    issue(3'd1, 3'd0, 4'd3, 4'd0, 16'h0001, 1'b1, 4'd0, 0, 16'h0, 1'b1);
    store_read("shl1", 4'd3, 16'h0002);
    alu(3'd6, 4'd3, 16'h8001);
    issue(3'd1, 3'd0, 4'd3, 4'd0, 16'hFFF1, 1'b1, 4'd0, 0, 16'h0, 1'b1);
    store_read("shr15", 4'd3, 16'h0001);
    alu(3'd6, 4'd3, 16'h8001);
    issue(3'd1, 3'd0, 4'd3, 4'd0, 16'h0010, 1'b1, 4'd0, 0, 16'h0, 1'b1);
    store_read("shl16", 4'd3, 16'h0000);

    // LUI
    issue(3'd4, 3'd0, 4'd8, 4'd0, 16'h12A5, 1'b1, 4'd0, 0, 16'h0, 1'b1);
    store_read("lui", 4'd8, 16'hA500);

`ifdef MULTICYCLE_DATAPATH_MUL_EN
    alu(3'd6, 4'd6, 16'h0123);
    alu(3'd7, 4'd6, 16'h0011);
    check("mul_latency", last_lat, 18);
    store_read("mul_res", 4'd6, 16'h1353);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      o = 3'($urandom_range(0, 7));
      im = (o == 3'd1 && $urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40) - 20) : 16'($urandom);
      issue(o, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            im, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 3), 16'($urandom), 1'b1);
    end
    for (int r = 0; r < 16; r++) store_read("final_reg", 4'(r), mreg[r]);

    // Reset in the middle of a memory request
    issue(3'd3, 3'd0, 4'd1, 4'd0, 16'h0, 1'b0, 4'd0, 50, 16'h0, 1'b0);
    k = 0;
    while (!mem_req && k < 10) begin @(negedge clk); k++; end
    if (!mem_req) bound_expired("abort_mem_req_wait");
    @(negedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    mem_q.delete();
    in_txn = 0;
    #1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_pc", pc, 16'h0000);
    check("abort_flags", flags, 5'h00);
    rc = retire_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("abort_no_retire", retire_cnt - rc, 0);
    alu(3'd6, 4'd9, 16'h5A5A);
    store_read("post_reset", 4'd9, 16'h5A5A);
    store_read("post_reset_r1", 4'd1, 16'h0000);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised next-generation CPU datapath: register file, ALU, shifter, flag register and program counter, sequenced by an internal FSM instead of external per-cycle control strobes.
- Accepts one decoded instruction per valid/ready handshake and runs it through execute, optional memory access and writeback.
- Talks to data memory over a req/ack handshake, so slow memories are tolerated.
- Sits between the decoder/controller and the memory interface.

Parameters:
- WIDTH, 16, datapath, register, immediate, PC and memory-address width.
- REGBITS, 4, register address width; 2**REGBITS registers.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inst_valid  in  1  decoded instruction present
- inst_ready  out  1  block can accept an instruction
- op  in  3  class: 0 ALU, 1 SHIFT, 2 LOAD, 3 STOR, 4 LUI, 5 BCOND, 6 JCOND, 7 JAL
- alu_op  in  3  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 MUL (optional)
- rdest  in  REGBITS  destination / first source register
- rsrc  in  REGBITS  second source register
- imm  in  WIDTH  sign-extended immediate
- use_imm  in  1  second operand = imm instead of R[rsrc]
- cond  in  4  branch/jump condition code
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  store data
- mem_rdata  in  WIDTH  load data, valid with mem_ack
- mem_ack  in  1  request completes this cycle
- pc  out  WIDTH  program counter
- flags  out  5  {N,Z,F,L,C}
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset state:
  - FSM state IDLE; pc=RESET_PC; flags=0.
  - All registers 0; mem_req=0, mem_we=0, retire=0.
  - inst_ready=1 once reset is released.
  - Reset asserted mid-operation aborts immediately; mem_req drops asynchronously.
- States: IDLE, EXEC, MEM, MUL (MUL only exists with the optional feature).
- IDLE:
  - inst_ready=1.
  - On inst_valid: capture all instruction fields and both operands (A=R[rdest], B = use_imm ? imm : R[rsrc]), then go to EXEC.
- EXEC, non-memory ops:
  - Result written, flags/pc updated, retire=1 for one cycle, return to IDLE.
  - Accept-to-retire latency is 2 edges.
- EXEC, LOAD/STOR: go to MEM.
  - mem_addr = R[rsrc]; mem_wdata = R[rdest].
  - mem_req held high with stable address/data until a cycle where mem_ack=1.
- MEM completion (on the mem_ack edge):
  - LOAD writes mem_rdata into R[rdest].
  - Retire, return to IDLE.
  - mem_ack while not in MEM is ignored.
- ALU ops (modulo 2**WIDTH):
  - ADD: A+B.
  - SUB: A-B.
  - CMP: no write.
  - AND/OR/XOR: bitwise.
  - MOV: result = B.
- Flags:
  - C: carry out (ADD) / borrow (SUB), ADD and SUB only.
  - F: signed overflow, ADD and SUB only.
  - CMP sets Z = (A==B), L = (A<B unsigned), N = (A<B signed).
  - AND/OR/XOR/MOV/shift/LUI/memory ops leave flags unchanged.
- SHIFT:
  - B interpreted as signed; positive = logical left, negative = logical right.
  - Magnitude >= WIDTH gives 0.
  - Result written to rdest.
- LUI: R[rdest] = {imm[7:0], 8'b0}; for WIDTH≠16 the immediate occupies the upper byte.
- Conditions:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 LO L; 5 HS !L; 6 LT N; 7 GE !N; 8 FS F; 9 FC !F.
  - 14 always; 15 and all others never.
- PC update:
  - BCOND taken: pc += imm.
  - JCOND taken: pc = R[rsrc].
  - JAL: R[rdest] = pc+1, pc = R[rsrc]; if rdest==rsrc the jump uses the old value.
  - All other cases: pc += 1.
  - All PC arithmetic wraps modulo 2**WIDTH.
- Captured operands do not track later register changes; one instruction is in flight at a time, so no hazards exist.

Optional Feature:
- Macro: MULTICYCLE_DATAPATH_MUL_EN.
- Defined:
  - alu_op 7 enters state MUL: iterative shift-add, one bit per cycle, WIDTH cycles.
  - Writes the low WIDTH bits of A*B to rdest, then retires; flags unchanged.
  - Accept-to-retire = WIDTH+2 edges.
- Undefined: alu_op 7 retires from EXEC with no register write, flags unchanged, pc += 1.

Test Plan:
- Reset: hold reset=0, release → pc=0, flags=0, inst_ready=1, R[0..15]=0 (read back via MOV/STOR).
- ALU/flags: R1=0x7FFF; ADD imm 1 → R1=0x8000, F=1, C=0. Then CMP R1 against imm 0x0001 → N=1, L=0, Z=0.
- Memory handshake: STOR with mem_ack delayed 3 cycles → mem_req high exactly 4 cycles with stable addr/data, single retire pulse. LOAD with mem_rdata=0xBEEF → rdest=0xBEEF.
- Branch/jump:
  - Z=1, BCOND EQ imm=-4 from pc=0x0010 → pc=0x000C.
  - cond=15 → pc=0x0011.
  - JAL with R2=0x0100, rdest=5 → R5=pc+1, pc=0x0100.
  - pc=0xFFFF plain op → pc=0x0000.
- Shift: R3=0x8001; SHIFT imm 1 → 0x0002; imm -15 → 0x0001; imm 16 → 0x0000.
- Reset mid-MEM: assert reset while mem_req=1 → mem_req=0 immediately, pc=RESET_PC, no retire. With MUL_EN: 0x0123*0x0011 → 0x1353 after 18 edges.
